// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter draining a one-cycle-latency FIFO.
// Divisor, parity and stop count are sampled once per frame at LOAD.
module uart_tx_cfg #(
    parameter int p_bit_cnt = 8,
    parameter int p_div_w   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [p_div_w-1:0]   i_div,
    input  logic [1:0]           i_parity,
    input  logic                 i_stop2,
    input  logic                 i_break,
    input  logic [p_bit_cnt-1:0] i_fifo_rd_data,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_rd_en,
    output logic                 o_sig,
    output logic                 o_busy
);
    localparam int frame_w = p_bit_cnt + 4;
    localparam int cnt_w   = $clog2(p_bit_cnt + 4) + 1;
    typedef enum logic [2:0] {IDLE, REQ, LOAD, SHIFT, BREAK} state_t;
    state_t             state_q;
    logic [frame_w-1:0] shift_q, frame_d;
    logic [p_div_w-1:0] div_q, div_cnt_q, div_d;
    logic [cnt_w-1:0]   bits_q, bits_d;
    logic               rd_en_q, sig_q, busy_q, par_en;
    always_comb begin
        par_en = (i_parity == 2'd1) || (i_parity == 2'd2);
        div_d = (i_div == '0) ? p_div_w'(1) : i_div;
        frame_d = '1;
        frame_d[0] = 1'b0;
        frame_d[p_bit_cnt:1] = i_fifo_rd_data;
        // odd mode is parity code 2, so bit 1 of the code inverts the even parity
        if (par_en) frame_d[p_bit_cnt+1] = (^i_fifo_rd_data) ^ i_parity[1];
        bits_d = cnt_w'(p_bit_cnt + 1) + (par_en ? cnt_w'(1) : cnt_w'(0)) + (i_stop2 ? cnt_w'(2) : cnt_w'(1));
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            sig_q   <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_break) begin
                        state_q <= BREAK;
                        sig_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (!i_fifo_empty) begin
                        state_q <= REQ;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                REQ: state_q <= LOAD;
                LOAD: begin
                    state_q   <= SHIFT;
                    sig_q     <= frame_d[0];
                    shift_q   <= {1'b1, frame_d[frame_w-1:1]};
                    bits_q    <= bits_d;
                    div_q     <= div_d;
                    div_cnt_q <= div_d - p_div_w'(1);
                end
                SHIFT: begin
                    if (div_cnt_q != '0) begin
                        div_cnt_q <= div_cnt_q - p_div_w'(1);
                    end else if (bits_q == cnt_w'(1)) begin
                        state_q <= IDLE;
                        sig_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        sig_q     <= shift_q[0];
                        shift_q   <= {1'b1, shift_q[frame_w-1:1]};
                        bits_q    <= bits_q - cnt_w'(1);
                        div_cnt_q <= div_q - p_div_w'(1);
                    end
                end
                BREAK: begin
                    if (!i_break) begin
                        state_q <= IDLE;
                        sig_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign o_fifo_rd_en = rd_en_q;
    assign o_sig        = sig_q;
    assign o_busy       = busy_q;
endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Runtime-configurable UART transmitter that drains a show-ahead-free FIFO (read data valid one cycle after read enable) and serialises each word LSB first with start, optional parity and one or two stop bits. It generalises the fixed-format transmitter: per-frame baud divisor, parity mode, stop-bit count and a line-break request. It sits between a transmit FIFO and the TX pad.

## Interface
- p_bit_cnt, 8: data bits per frame (5..9), width of FIFO read data.
- p_div_w, 16: width of the baud divisor input.
- i_clk  in  1  system clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_div  in  p_div_w  clock cycles per bit; 0 is treated as 1.
- i_parity  in  2  0 = none, 1 = even, 2 = odd, 3 = none.
- i_stop2  in  1  0 = one stop bit, 1 = two stop bits.
- i_break  in  1  request to hold the line low (break).
- i_fifo_rd_data  in  p_bit_cnt  FIFO read data, valid the cycle after o_fifo_rd_en.
- i_fifo_empty  in  1  FIFO empty flag.
- o_fifo_rd_en  out  1  one-cycle FIFO pop.
- o_sig  out  1  serial line, idle high.
- o_busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, REQ, LOAD, SHIFT, BREAK.
- IDLE: if i_break -> BREAK (priority over FIFO); else if ~i_fifo_empty -> REQ; else stay.
- REQ: o_fifo_rd_en = 1 for exactly this cycle; -> LOAD.
- LOAD: capture i_fifo_rd_data, i_div, i_parity, i_stop2 into frame registers; build shift register {stop bit(s) = 1, parity (if enabled), data, start = 0}; bit count = 1 + p_bit_cnt + (parity ? 1 : 0) + (i_stop2 ? 2 : 1); -> SHIFT.
- SHIFT: o_sig = shift[0]; each bit held for the latched divisor; shift right, filling with 1; after the last stop bit period -> IDLE.
- Parity bit: even = XOR of data bits; odd = its inverse.
- Config inputs changing during SHIFT do not affect the frame in flight; they take effect at the next LOAD.
- BREAK: o_sig = 0 while i_break = 1; on i_break = 0 -> IDLE. i_break asserted outside IDLE is ignored until the current frame completes.
- o_sig = 1 in IDLE, REQ and LOAD.
- Divisor counter width p_div_w; bit counter width clog2(p_bit_cnt + 4) + 1.

## Timing
- Reset: state IDLE, o_sig = 1, o_fifo_rd_en = 0, o_busy = 0 on the cycle after i_rst is sampled high. Frame registers are don't-care.
- Reset mid-frame: frame aborted, line high the next cycle, popped word lost, no further pop until reset is released.
- Latency: i_fifo_empty low in IDLE at cycle t -> o_fifo_rd_en high at t+1 -> data captured at t+2 -> start bit on o_sig from t+3.
- Frame duration on the line: bit count × divisor cycles exactly.
- Back-to-back: with FIFO non-empty, exactly 3 high cycles (IDLE, REQ, LOAD) between the end of the last stop bit and the next start bit.
- Break: o_sig low from the cycle after BREAK is entered until the cycle after i_break is sampled low.
- o_fifo_rd_en is never asserted while i_fifo_empty was high in the preceding IDLE cycle.

## Test plan
- 8N1, div = 4, push 0x55 -> rd_en pulse 1 cycle, o_sig = 0,1,0,1,0,1,0,1,0,1 each 4 cycles (40 total), then high.
- p_bit_cnt = 7, even parity, i_stop2 = 1, div = 2, data 0x03 -> start, 1,1,0,0,0,0,0, parity 0, stop 1,1; 22 cycles.
- Odd parity, div = 1, data 0x00 -> parity bit 1; div = 0 gives a waveform identical to div = 1.
- Three words queued, div = 3 -> three rd_en pulses, exactly 3 high cycles between frames; i_div changed mid-frame affects only the next frame.
- i_rst pulsed during data bit 3 -> o_sig = 1 and o_busy = 0 the next cycle; after release, the next FIFO word is sent intact.
- i_break high while idle with FIFO non-empty -> line low, no rd_en until i_break drops; i_break raised mid-frame -> frame completes first.
